dma_copy_engine: RTL

//   Bus initiator (master) that drives the shared 16-bit addr/wdata/write_en/read_en bus into
//   the memory-map decoder. Copies LEN words from SRC to DST, or fills DST with a constant.

---
 rtl/dma_copy_engine.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dma_copy_engine.sv
// Bus-initiator copy/fill engine: moves LEN words SRC->DST, or fills DST with a constant,
// over the shared 16-bit addr/wdata/we/re bus. All outputs are registered.
module dma_copy_engine #(
    parameter int          RD_LAT  = 1,
    parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        fill_mode,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    input  logic [15:0] fill_val,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] remaining,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [15:0] bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RWAIT,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [16:0] MAX_LEN_X = {1'b0, MAX_LEN};

    state_t      state;
    logic [15:0] src_cur;
    logic [15:0] dst_cur;
    logic [15:0] fill_q;
    logic        mode_q;
    logic        abort_q;

    logic [15:0] src_next;
    logic [15:0] dst_next;
    logic [15:0] rem_next;
    logic        start_bad;

    assign src_next  = src_cur + 16'd1;
    assign dst_next  = dst_cur + 16'd1;
    assign rem_next  = remaining - 16'd1;
    // IMEM (region 0x0) is read-only, so it can never be a destination.
    assign start_bad = ({1'b0, len} > MAX_LEN_X) || (dst[15:12] == 4'h0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            src_cur   <= '0;
            dst_cur   <= '0;
            fill_q    <= '0;
            mode_q    <= 1'b0;
            abort_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            remaining <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults first; a later assignment in the same
            // block overrides them, so every strobe is a one-cycle pulse unless re-armed.
            bus_re    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            done      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q    <= fill_mode;
                        fill_q    <= fill_val;
                        src_cur   <= src;
                        dst_cur   <= dst;
                        remaining <= len;
                        abort_q   <= 1'b0;
                        if (len == 16'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b0;
                        end else if (start_bad) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            err  <= 1'b0;
                            busy <= 1'b1;
                            if (fill_mode) begin
                                state     <= S_WR;
                                bus_addr  <= dst;
                                bus_wdata <= fill_val;
                                bus_we    <= 1'b1;
                            end else begin
                                state    <= S_RD;
                                bus_addr <= src;
                                bus_re   <= 1'b1;
                            end
                        end
                    end
                end

                S_RD: begin
                    if (RD_LAT == 0) begin
                        if (abort) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_WR;
                            bus_addr  <= dst_cur;
                            bus_wdata <= bus_rdata;
                            bus_we    <= 1'b1;
                        end
                    end else begin
                        // Read still in flight: hold address and enable, remember any abort.
                        state    <= S_RWAIT;
                        bus_addr <= bus_addr;
                        bus_re   <= 1'b1;
                        abort_q  <= abort;
                    end
                end

                S_RWAIT: begin
                    if (abort || abort_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state     <= S_WR;
                        bus_addr  <= dst_cur;
                        bus_wdata <= bus_rdata;
                        bus_we    <= 1'b1;
                    end
                end

                S_WR: begin
                    dst_cur   <= dst_next;
                    remaining <= rem_next;
                    if (!mode_q) src_cur <= src_next;
                    if (rem_next == 16'd0 || abort) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (dst_next[15:12] == 4'h0) begin
                        // Destination wrapped into IMEM: stop before touching it.
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (mode_q) begin
                        state     <= S_WR;
                        bus_addr  <= dst_next;
                        bus_wdata <= fill_q;
                        bus_we    <= 1'b1;
                    end else begin
                        state    <= S_RD;
                        bus_addr <= src_next;
                        bus_re   <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
